// File: rtl/sndcmd_mailbox.sv
// sndcmd_mailbox: sound-command mailbox from the main Z80 to the sound Z80.
// The main CPU writes command bytes to an I/O port. The sound CPU is paced
// with one NMI per queued command and reads the bytes from a memory address.
// Build option: define SNDCMD_FIFO_EN for a 2^DEPTH_LOG2-entry FIFO. Leave it
// undefined for the original single latch plus valid flag.
module sndcmd_mailbox #(
  parameter logic [7:0]  CMD_PORT   = 8'h14,
  parameter logic [15:0] RD_ADDR    = 16'hE000,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  m_adr,
  input  logic [7:0]  m_dout,
  input  logic        m_ix,
  input  logic        m_wr,
  input  logic [15:0] s_adr,
  input  logic        s_mx,
  input  logic        s_rd,
  input  logic        s_m1,
  output logic        s_sel,
  output logic [7:0]  s_data,
  output logic        s_nmireq,
  output logic        empty,
  output logic        full,
  output logic        ovf
);

  logic       wsel, wsel_q, rsel_q, nack, nack_q;
  logic       push, pop, nack_rise, drop;
  logic       in_service;
  logic       is_empty, is_full;
  logic [7:0] head;

  assign wsel      = m_ix & m_wr & (m_adr == CMD_PORT);
  assign s_sel     = s_mx & s_rd & (s_adr == RD_ADDR);
  assign nack      = s_m1 & s_mx & s_rd & (s_adr == 16'h0066);
  // A strobe held for several clocks still counts as one bus cycle.
  assign push      = wsel & ~wsel_q;
  // Pop only once the read has finished, so data never changes mid-read.
  assign pop       = ~s_sel & rsel_q & ~is_empty;
  assign nack_rise = nack & ~nack_q;

`ifdef SNDCMD_FIFO_EN
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  accept;

  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH_CNT);
  assign head     = mem[rd_ptr];
  // A simultaneous pop frees a slot, so a write while full still lands.
  assign accept   = push & (~is_full | pop);
  assign drop     = push & is_full & ~pop;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (accept && !pop)      count <= count + (DEPTH_LOG2 + 1)'(1);
      else if (pop && !accept) count <= count - (DEPTH_LOG2 + 1)'(1);
    end
  end

  // Command storage.
  // NOTE: the storage array has no reset; empty slots are never observed
  // because s_data is forced to 8'hFF while the count is zero.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= m_dout;
  end
`else
  logic [7:0] latch_q;
  logic       valid;
  logic       unused_depth;

  // Depth only matters for the FIFO build.
  assign unused_depth = |DEPTH_LOG2;
  assign is_empty     = ~valid;
  assign is_full      = valid;
  assign head         = latch_q;
  // A pop in the same clock consumes the old byte, so that is no overwrite.
  assign drop         = push & valid & ~pop;

  // Single latch plus valid flag; every write overwrites the latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q <= 8'h00;
      valid   <= 1'b0;
    end else begin
      if (push) latch_q <= m_dout;
      valid <= push | (valid & ~pop);
    end
  end
`endif

  assign empty  = is_empty;
  assign full   = is_full;
  assign s_data = is_empty ? 8'hFF : head;

  // Edge registers, NMI service flag, NMI request and overflow pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      nack_q     <= 1'b0;
      in_service <= 1'b0;
      s_nmireq   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      wsel_q <= wsel;
      rsel_q <= s_sel;
      nack_q <= nack;
      // A fresh acknowledge wins over a pop landing in the same clock.
      if (nack_rise) in_service <= 1'b1;
      else if (pop)  in_service <= 1'b0;
      // Built from the registered state, so the request trails a push or a
      // pop by one clock and the T80 sees a clean new edge per command.
      s_nmireq <= ~is_empty & ~in_service;
      ovf      <= drop;
    end
  end

endmodule

// File: tb/tb_sndcmd_mailbox.sv
// tb_sndcmd_mailbox: directed scenarios plus randomized bus traffic for
// sndcmd_mailbox, checked every clock against a queue-based reference model.
// Build option: SNDCMD_FIFO_EN selects the FIFO flavour for DUT and model.
module tb_sndcmd_mailbox;

  localparam int DEPTH_LOG2 = 2;
`ifdef SNDCMD_FIFO_EN
  localparam int CAP = 1 << DEPTH_LOG2;
`else
  localparam int CAP = 1;
`endif

  logic        clk, reset_n;
  logic [7:0]  m_adr, m_dout;
  logic        m_ix, m_wr;
  logic [15:0] s_adr;
  logic        s_mx, s_rd, s_m1;
  logic        s_sel, s_nmireq, empty, full, ovf;
  logic [7:0]  s_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  sndcmd_mailbox #(
    .CMD_PORT  (8'h14),
    .RD_ADDR   (16'hE000),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_adr   (m_adr),
    .m_dout  (m_dout),
    .m_ix    (m_ix),
    .m_wr    (m_wr),
    .s_adr   (s_adr),
    .s_mx    (s_mx),
    .s_rd    (s_rd),
    .s_m1    (s_m1),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .s_nmireq(s_nmireq),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending commands as a plain queue; the NMI request is "something queued
  // and not in service" as of the previous clock.
  byte unsigned q[$];
  bit mdl_wprev, mdl_rprev, mdl_nprev, mdl_insvc, mdl_nmi, mdl_ovf;
  bit mw, mr, mn, mpush, mpop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mdl_wprev = 0; mdl_rprev = 0; mdl_nprev = 0;
      mdl_insvc = 0; mdl_nmi = 0; mdl_ovf = 0;
    end else begin
      mw    = m_ix && m_wr && (m_adr == 8'h14);
      mr    = s_mx && s_rd && (s_adr == 16'hE000);
      mn    = s_m1 && s_mx && s_rd && (s_adr == 16'h0066);
      mpush = mw && !mdl_wprev;
      mpop  = !mr && mdl_rprev && (q.size() > 0);
      mdl_nmi = (q.size() > 0) && !mdl_insvc;
      mdl_ovf = 0;
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        if (q.size() < CAP) q.push_back(m_dout);
        else begin
          mdl_ovf = 1;
`ifndef SNDCMD_FIFO_EN
          q.delete();
          q.push_back(m_dout);
`endif
        end
      end
      if (mn && !mdl_nprev) mdl_insvc = 1;
      else if (mpop)        mdl_insvc = 0;
      mdl_wprev = mw; mdl_rprev = mr; mdl_nprev = mn;
    end
  end

  // Compare every output on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("s_sel",    s_sel,    16'(s_mx && s_rd && (s_adr == 16'hE000)));
      check("s_data",   s_data,   16'((q.size() > 0) ? q[0] : 8'hFF));
      check("s_nmireq", s_nmireq, 16'(mdl_nmi));
      check("empty",    empty,    16'(q.size() == 0));
      check("full",     full,     16'(q.size() == CAP));
      check("ovf",      ovf,      16'(mdl_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    m_ix = 0; m_wr = 0; m_adr = 8'h00; m_dout = 8'h00;
    s_mx = 0; s_rd = 0; s_m1 = 0; s_adr = 16'h0000;
  endtask

  task automatic do_reset();
    bus_idle();
    reset_n = 0;
    tick(2);
    reset_n = 1;
    tick(1);
  endtask

  task automatic main_write(input logic [7:0] d, input int hold);
    m_ix = 1; m_wr = 1; m_adr = 8'h14; m_dout = d;
    tick(hold);
    m_ix = 0; m_wr = 0;
  endtask

  task automatic nmi_ack();
    s_m1 = 1; s_mx = 1; s_rd = 1; s_adr = 16'h0066;
    tick(2);
    s_m1 = 0; s_mx = 0; s_rd = 0; s_adr = 16'h0000;
  endtask

  // Starts a read, checks the byte, holds it; caller ends it.
  task automatic read_begin(input string name, input logic [7:0] exp);
    s_mx = 1; s_rd = 1; s_adr = 16'hE000;
    #1;
    check({name, "_sel"}, s_sel, 16'h1);
    check(name, s_data, 16'(exp));
    tick(2);
  endtask

  task automatic read_end();
    s_mx = 0; s_rd = 0; s_adr = 16'h0000;
  endtask

  task automatic wait_nmi(input string name);
    for (int i = 0; i < 20 && !s_nmireq; i++) tick(1);
    check(name, s_nmireq, 16'h1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1;
    bus_idle();
    #1 reset_n = 0;
    tick(2);
    reset_n = 1;
    cmp_en = 1;
    tick(1);

    // Reset state and a read of an empty mailbox.
    check("rst_nmireq", s_nmireq, 16'h0);
    check("rst_empty",  empty,    16'h1);
    check("rst_full",   full,     16'h0);
    check("rst_ovf",    ovf,      16'h0);
    read_begin("rst_read", 8'hFF);
    read_end();
    tick(1);
    check("rst_nopop", empty, 16'h1);

    // Single command, strobe held 3 clocks.
    m_ix = 1; m_wr = 1; m_adr = 8'h14; m_dout = 8'h5A;
    tick(1);
    check("w1_empty",  empty,    16'h0);
    check("w1_nmi_e0", s_nmireq, 16'h0);
    tick(1);
    check("w1_nmi_e1", s_nmireq, 16'h1);
    tick(1);
    m_ix = 0; m_wr = 0;
    tick(2);
    check("w1_ovf",  ovf,  16'h0);
    check("w1_full", full, 16'(CAP == 1));
    nmi_ack();
    check("w1_ack_nmi", s_nmireq, 16'h0);
    read_begin("w1_read", 8'h5A);
    read_end();
    tick(1);
    check("w1_empty_after", empty, 16'h1);
    check("w1_data_after",  s_data, 16'h00FF);
    tick(2);
    check("w1_nmi_idle", s_nmireq, 16'h0);

`ifdef SNDCMD_FIFO_EN
    // Three queued commands, serviced in order.
    do_reset();
    main_write(8'h01, 1); tick(1);
    main_write(8'h02, 1); tick(1);
    main_write(8'h03, 1); tick(1);
    for (int k = 0; k < 3; k++) begin
      wait_nmi("f3_nmi");
      nmi_ack();
      read_begin("f3_read", 8'(k + 1));
      read_end();
      tick(1);
      check("f3_nmi_pop", s_nmireq, 16'h0);
      tick(1);
      check("f3_nmi_rerise", s_nmireq, 16'(k < 2));
    end

    // Overflow: the fifth write into a 4-deep FIFO is dropped.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      main_write(8'(8'h11 + i), 1);
      tick(1);
    end
    check("ov_full", full, 16'h1);
    check("ov_ovf0", ovf,  16'h0);
    m_ix = 1; m_wr = 1; m_adr = 8'h14; m_dout = 8'h15;
    tick(1);
    check("ov_ovf_pulse", ovf, 16'h1);
    m_ix = 0; m_wr = 0;
    tick(1);
    check("ov_ovf_end",  ovf,  16'h0);
    check("ov_full_kept", full, 16'h1);

    // Simultaneous push and pop while full.
    wait_nmi("sp_nmi");
    nmi_ack();
    read_begin("sp_read0", 8'h11);
    read_end();
    m_ix = 1; m_wr = 1; m_adr = 8'h14; m_dout = 8'h20;
    tick(1);
    check("sp_ovf",  ovf,  16'h0);
    check("sp_full", full, 16'h1);
    m_ix = 0; m_wr = 0;
    begin
      logic [7:0] exp_rest [4];
      exp_rest[0] = 8'h12; exp_rest[1] = 8'h13;
      exp_rest[2] = 8'h14; exp_rest[3] = 8'h20;
      for (int k = 0; k < 4; k++) begin
        wait_nmi("sp_nmi_k");
        nmi_ack();
        read_begin("sp_read", exp_rest[k]);
        read_end();
        tick(1);
      end
    end
    check("sp_empty", empty, 16'h1);
`else
    // Latch build: an unread byte is overwritten and flagged.
    do_reset();
    main_write(8'hAA, 1);
    tick(1);
    m_ix = 1; m_wr = 1; m_adr = 8'h14; m_dout = 8'hBB;
    tick(1);
    check("lt_ovf_pulse", ovf, 16'h1);
    m_ix = 0; m_wr = 0;
    tick(1);
    check("lt_ovf_end", ovf,  16'h0);
    check("lt_full",    full, 16'h1);
    wait_nmi("lt_nmi");
    nmi_ack();
    read_begin("lt_read", 8'hBB);
    read_end();
    tick(1);
    check("lt_empty", empty, 16'h1);
`endif

    // Reset in the middle of traffic discards the pending command.
    do_reset();
    main_write(8'h77, 1);
    tick(3);
    reset_n = 0;
    #1;
    check("mr_empty",  empty,    16'h1);
    check("mr_nmireq", s_nmireq, 16'h0);
    tick(1);
    reset_n = 1;
    tick(2);
    check("mr_still_empty", empty, 16'h1);

    // Randomized bus traffic checked by the model every clock.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2) == 0) begin
        m_ix   = 1'($urandom_range(1));
        m_wr   = 1'($urandom_range(1));
        m_adr  = ($urandom_range(3) != 0) ? 8'h14 : 8'($urandom);
        m_dout = 8'($urandom);
      end
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(7))
          0, 1, 2: begin s_mx = 0; s_rd = 0; s_m1 = 0; s_adr = 16'h0000; end
          3, 4:    begin s_mx = 1; s_rd = 1; s_m1 = 0; s_adr = 16'hE000; end
          5:       begin s_mx = 1; s_rd = 1; s_m1 = 1; s_adr = 16'h0066; end
          6:       begin s_mx = 1; s_rd = 1; s_m1 = 1'($urandom_range(1));
                         s_adr = 16'($urandom); end
          default: begin s_mx = 1'($urandom_range(1)); s_rd = 1'($urandom_range(1));
                         s_m1 = 0; s_adr = 16'hE000; end
        endcase
      end
      if (c == 1500) begin
        #2 reset_n = 0;
        #4 reset_n = 1;
      end
      tick(1);
    end

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
